// File: rtl/core_sequencer_if.sv
// Sequencer-side bundle: instruction fetch handshake, datapath start/done handshake and status.
// master = core_sequencer, slave = memory/datapath side.
interface core_sequencer_if #(
    parameter int WIDTH        = 12,
    parameter int BSTACK_DEPTH = 8
);
    localparam int CW = $clog2(BSTACK_DEPTH + 1);

    logic             stall;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             exec_start;
    logic             exec_done;
    logic [2:0]       pc_op;
    logic             cond;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [2:0]       state;
    logic             halted;
    logic [CW-1:0]    bs_count;
    logic             bs_overflow;
    logic             bs_underflow;

    modport master (
        input  stall, imem_ack, imem_rdata, exec_done, pc_op, cond, target,
        output imem_req, imem_addr, instr, instr_valid, exec_start,
               pc, state, halted, bs_count, bs_overflow, bs_underflow
    );

    modport slave (
        output stall, imem_ack, imem_rdata, exec_done, pc_op, cond, target,
        input  imem_req, imem_addr, instr, instr_valid, exec_start,
               pc, state, halted, bs_count, bs_overflow, bs_underflow
    );
endinterface

// File: rtl/core_sequencer.sv
// Multicycle CPU control unit: PC, instruction register, FETCH..INCR_PC FSM and hardware branch stack.
// Minimum 5 cycles/instruction; BSTACK_AUTOPOP_EN makes a not-taken BRANCH_IF pop the branch stack.
module core_sequencer #(
    parameter int               WIDTH        = 12,
    parameter int               BSTACK_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    core_sequencer_if.master bus
);
    localparam int CW = $clog2(BSTACK_DEPTH + 1);
    localparam int PW = (BSTACK_DEPTH > 1) ? $clog2(BSTACK_DEPTH) : 1;

    localparam logic [2:0] OP_DIRECT    = 3'd1;
    localparam logic [2:0] OP_BRANCH_IF = 3'd2;
    localparam logic [2:0] OP_PUSH      = 3'd3;
    localparam logic [2:0] OP_POP       = 3'd4;
    localparam logic [2:0] OP_HALT      = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_INCR   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] instr_r;
    logic             req_hold;
    logic             instr_valid_r;
    logic             exec_start_r;
    logic             halted_r;
    logic             ovf_r;
    logic             unf_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] bstack [BSTACK_DEPTH];

    logic             fetch_req;
    logic             empty;
    logic             full;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    push_idx;
    logic [WIDTH-1:0] pc_inc;
    logic             push_en;

    // Once raised the request is held until ack, regardless of stall.
    assign fetch_req = (st == S_FETCH) && (req_hold || !bus.stall) && !RESET;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(BSTACK_DEPTH));
    assign top_idx  = PW'(cnt - CW'(1));
    assign push_idx = PW'(cnt);
    assign pc_inc   = pc_r + WIDTH'(1);
    assign push_en  = (st == S_WB) && bus.exec_done && (bus.pc_op == OP_PUSH) && !full;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st            <= S_FETCH;
            pc_r          <= RESET_PC;
            next_pc       <= RESET_PC;
            instr_r       <= '0;
            req_hold      <= 1'b0;
            instr_valid_r <= 1'b0;
            exec_start_r  <= 1'b0;
            halted_r      <= 1'b0;
            ovf_r         <= 1'b0;
            unf_r         <= 1'b0;
            cnt           <= '0;
        end else begin
            instr_valid_r <= 1'b0;
            exec_start_r  <= 1'b0;
            case (st)
                S_FETCH: begin
                    if (fetch_req) begin
                        if (bus.imem_ack) begin
                            instr_r       <= bus.imem_rdata;
                            req_hold      <= 1'b0;
                            instr_valid_r <= 1'b1;
                            st            <= S_DECODE;
                        end else begin
                            req_hold <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    exec_start_r <= 1'b1;
                    st           <= S_EXEC;
                end
                S_EXEC: st <= S_WB;
                S_WB: begin
                    if (bus.exec_done) begin
                        next_pc <= pc_inc;
                        st      <= S_INCR;
                        case (bus.pc_op)
                            OP_DIRECT: next_pc <= bus.target;
                            OP_BRANCH_IF: begin
                                if (empty) begin
                                    unf_r <= 1'b1;
                                end else if (bus.cond) begin
                                    next_pc <= bstack[top_idx];
                                end else begin
`ifdef BSTACK_AUTOPOP_EN
                                    cnt <= cnt - CW'(1);
`endif
                                end
                            end
                            OP_PUSH: begin
                                if (full) ovf_r <= 1'b1;
                                else      cnt   <= cnt + CW'(1);
                            end
                            OP_POP: begin
                                if (empty) unf_r <= 1'b1;
                                else       cnt   <= cnt - CW'(1);
                            end
                            OP_HALT: begin
                                halted_r <= 1'b1;
                                st       <= S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_INCR: begin
                    pc_r <= next_pc;
                    st   <= S_FETCH;
                end
                S_HALT: ;
                default: st <= S_FETCH;
            endcase
        end
    end

    // Entries are never cleared; only the occupancy count moves on pop.
    always_ff @(posedge CLK) begin
        if (push_en) bstack[push_idx] <= bus.target;
    end

    assign bus.imem_req     = fetch_req;
    assign bus.imem_addr    = pc_r;
    assign bus.instr        = instr_r;
    assign bus.instr_valid  = instr_valid_r;
    assign bus.exec_start   = exec_start_r;
    assign bus.pc           = pc_r;
    assign bus.state        = st;
    assign bus.halted       = halted_r;
    assign bus.bs_count     = cnt;
    assign bus.bs_overflow  = ovf_r;
    assign bus.bs_underflow = unf_r;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed table, randomized instruction stream against a queue-based model,
// reset-in-WRITE_BACK and HALT sequences.
module tb_core_sequencer;
    localparam int W = 12;
    localparam int D = 8;
`ifdef BSTACK_AUTOPOP_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    typedef struct {
        logic [2:0]   op;
        logic         c;
        logic [W-1:0] tgt;
        int           ack_dly;
        int           done_dly;
        bit           sm;
        logic [W-1:0] epc;
        int           ecnt;
        bit           eov;
        bit           eun;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET;

    core_sequencer_if #(.WIDTH(W), .BSTACK_DEPTH(D)) bus ();

    core_sequencer #(.WIDTH(W), .BSTACK_DEPTH(D), .RESET_PC(12'h000)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mpc;
    logic [W-1:0] mstk [$];
    bit           movf, munf, mhalt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mpc = 12'h000;
        mstk.delete();
        movf = 1'b0;
        munf = 1'b0;
        mhalt = 1'b0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic c, input logic [W-1:0] tgt);
        logic [W-1:0] inc;
        inc = mpc + 12'd1;
        case (op)
            3'd1: mpc = tgt;
            3'd2: begin
                if (mstk.size() == 0) begin
                    munf = 1'b1;
                    mpc = inc;
                end else if (c) begin
                    mpc = mstk[$];
                end else begin
                    mpc = inc;
                    if (AP) void'(mstk.pop_back());
                end
            end
            3'd3: begin
                if (mstk.size() == D) movf = 1'b1;
                else mstk.push_back(tgt);
                mpc = inc;
            end
            3'd4: begin
                if (mstk.size() == 0) munf = 1'b1;
                else void'(mstk.pop_back());
                mpc = inc;
            end
            3'd5: mhalt = 1'b1;
            default: mpc = inc;
        endcase
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_pc"}, 32'(bus.pc), 32'(mpc));
        chk({tag, "_cnt"}, 32'(bus.bs_count), mstk.size());
        chk({tag, "_ovf"}, 32'(bus.bs_overflow), 32'(movf));
        chk({tag, "_unf"}, 32'(bus.bs_underflow), 32'(munf));
        chk({tag, "_halted"}, 32'(bus.halted), 32'(mhalt));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, 32'(bus.pc), 0);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_instr"}, 32'(bus.instr), 0);
        chk({tag, "_cnt"}, 32'(bus.bs_count), 0);
        chk({tag, "_ovf"}, 32'(bus.bs_overflow), 0);
        chk({tag, "_unf"}, 32'(bus.bs_underflow), 0);
        chk({tag, "_halted"}, 32'(bus.halted), 0);
        chk({tag, "_req"}, 32'(bus.imem_req), 0);
        chk({tag, "_ivalid"}, 32'(bus.instr_valid), 0);
        chk({tag, "_estart"}, 32'(bus.exec_start), 0);
    endtask

    // Entered and left #1 after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [2:0] op, input logic c, input logic [W-1:0] tgt,
                             input int ack_dly, input int done_dly, input bit stall_mix,
                             input bit rst_in_wb);
        logic [W-1:0] rd, pc_before;
        bit raised, got;
        int k, cycles;
        rd = W'($urandom);
        raised = 1'b0;
        got = 1'b0;
        k = 0;
        cycles = 0;
        for (int cyc = 0; cyc < 64 && !got; cyc++) begin
            bus.stall = stall_mix ? ((cyc < 2) ? 1'b1 : 1'($urandom)) : 1'b0;
            #1;
            chk("fetch_state", 32'(bus.state), 0);
            if (raised) chk("req_held", 32'(bus.imem_req), 1);
            if (bus.stall && !raised) chk("stall_blocks_req", 32'(bus.imem_req), 0);
            if (bus.imem_req) begin
                if (!raised) chk("fetch_addr", 32'(bus.imem_addr), 32'(mpc));
                else chk("addr_stable", 32'(bus.imem_addr), 32'(mpc));
                raised = 1'b1;
                if (k == ack_dly) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = rd;
                    got = 1'b1;
                end
                k++;
            end else if (stall_mix) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = ~rd;
            end
            @(posedge CLK);
            #1;
            bus.imem_ack = 1'b0;
            cycles++;
        end
        bus.stall = 1'b0;
        if (!got) begin
            chk("ack_timeout", 32'(got), 1);
            return;
        end
        chk("decode_state", 32'(bus.state), 1);
        chk("instr_valid_hi", 32'(bus.instr_valid), 1);
        chk("instr", 32'(bus.instr), 32'(rd));
        chk("req_off_decode", 32'(bus.imem_req), 0);
        if (stall_mix) begin
            bus.exec_done = 1'b1;
            bus.pc_op = 3'd1;
            bus.target = ~tgt;
        end
        @(posedge CLK);
        #1;
        cycles++;
        chk("exec_state", 32'(bus.state), 2);
        chk("instr_valid_lo", 32'(bus.instr_valid), 0);
        chk("exec_start_hi", 32'(bus.exec_start), 1);
        @(posedge CLK);
        #1;
        cycles++;
        bus.exec_done = 1'b0;
        chk("wb_state", 32'(bus.state), 3);
        chk("exec_start_lo", 32'(bus.exec_start), 0);
        if (rst_in_wb) begin
            RESET = 1'b1;
            #1;
            check_reset("rst_wb");
            @(posedge CLK);
            #1;
            RESET = 1'b0;
            model_reset();
            return;
        end
        for (int i = 0; i < done_dly; i++) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        chk("wb_wait", 32'(bus.state), 3);
        pc_before = mpc;
        bus.exec_done = 1'b1;
        bus.pc_op = op;
        bus.cond = c;
        bus.target = tgt;
        @(posedge CLK);
        #1;
        cycles++;
        bus.exec_done = 1'b0;
        bus.pc_op = 3'($urandom);
        bus.cond = 1'($urandom);
        bus.target = W'($urandom);
        model_exec(op, c, tgt);
        if (op == 3'd5) begin
            chk("halt_state", 32'(bus.state), 5);
            check_status("halt");
            return;
        end
        chk("incr_state", 32'(bus.state), 4);
        chk("incr_pc_hold", 32'(bus.pc), 32'(pc_before));
        @(posedge CLK);
        #1;
        cycles++;
        chk("refetch_state", 32'(bus.state), 0);
        check_status("after");
        if (!stall_mix) chk("instr_cycles", cycles, 5 + ack_dly + done_dly);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic c, input logic [W-1:0] tgt,
                                input int ad, input int dd, input bit sm,
                                input logic [W-1:0] epc, input int ecnt, input bit eov, input bit eun);
        vec_t v;
        v.op = op; v.c = c; v.tgt = tgt; v.ack_dly = ad; v.done_dly = dd; v.sm = sm;
        v.epc = epc; v.ecnt = ecnt; v.eov = eov; v.eun = eun;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        vec_t v;
        RESET = 1'b1;
        bus.stall = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.exec_done = 1'b0;
        bus.pc_op = 3'd0;
        bus.cond = 1'b0;
        bus.target = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset("reset");
        RESET = 1'b0;

        tbl.push_back(mk(3'd0, 1'b0, 12'h000, 0, 0, 1'b0, 12'h001, 0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 1'b0, 12'h000, 3, 0, 1'b1, 12'h002, 0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 1'b0, 12'h000, 1, 2, 1'b0, 12'h003, 0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd1, 1'b0, 12'h020, 0, 0, 1'b0, 12'h020, 0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd3, 1'b0, 12'h020, 0, 1, 1'b0, 12'h021, 1, 1'b0, 1'b0));
        tbl.push_back(mk(3'd1, 1'b0, 12'h025, 0, 0, 1'b0, 12'h025, 1, 1'b0, 1'b0));
        tbl.push_back(mk(3'd2, 1'b1, 12'h0AA, 0, 0, 1'b0, 12'h020, 1, 1'b0, 1'b0));
        tbl.push_back(mk(3'd1, 1'b0, 12'h025, 0, 0, 1'b0, 12'h025, 1, 1'b0, 1'b0));
        tbl.push_back(mk(3'd2, 1'b0, 12'h000, 0, 0, 1'b0, 12'h026, AP ? 0 : 1, 1'b0, 1'b0));
        tbl.push_back(mk(3'd4, 1'b0, 12'h000, 0, 0, 1'b0, 12'h027, 0, 1'b0, AP));
        tbl.push_back(mk(3'd4, 1'b0, 12'h000, 0, 0, 1'b0, 12'h028, 0, 1'b0, 1'b1));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(3'd3, 1'b0, W'(12'h100 + i), 0, 0, 1'b0, W'(12'h029 + i),
                             (i < 8) ? i + 1 : 8, (i == 8), 1'b1));
        tbl.push_back(mk(3'd2, 1'b1, 12'h000, 0, 0, 1'b0, 12'h107, 8, 1'b1, 1'b1));
        tbl.push_back(mk(3'd1, 1'b0, 12'hFFF, 0, 0, 1'b0, 12'hFFF, 8, 1'b1, 1'b1));
        tbl.push_back(mk(3'd0, 1'b0, 12'h000, 0, 0, 1'b0, 12'h000, 8, 1'b1, 1'b1));
        tbl.push_back(mk(3'd1, 1'b0, 12'h7A0, 2, 1, 1'b1, 12'h7A0, 8, 1'b1, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            run_instr(v.op, v.c, v.tgt, v.ack_dly, v.done_dly, v.sm, 1'b0);
            chk("tbl_pc", 32'(bus.pc), 32'(v.epc));
            chk("tbl_cnt", 32'(bus.bs_count), v.ecnt);
            chk("tbl_ovf", 32'(bus.bs_overflow), 32'(v.eov));
            chk("tbl_unf", 32'(bus.bs_underflow), 32'(v.eun));
        end

        for (int n = 0; n < 150; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd5) op = 3'd3;
            run_instr(op, 1'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        run_instr(3'd0, 1'b0, 12'h000, 1, 0, 1'b0, 1'b1);
        run_instr(3'd0, 1'b0, 12'h000, 0, 0, 1'b0, 1'b0);
        run_instr(3'd5, 1'b0, 12'h000, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.exec_done = 1'($urandom);
            bus.pc_op = 3'd1;
            bus.target = W'($urandom);
            @(posedge CLK);
            #1;
            chk("halt_no_req", 32'(bus.imem_req), 0);
            chk("halt_stays", 32'(bus.state), 5);
            chk("halt_pc", 32'(bus.pc), 32'(mpc));
        end
        bus.exec_done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Parametrised multicycle control unit for the CPU core: owns the PC, the instruction register and the FETCH/DECODE/EXEC/WRITE_BACK/INCR_PC state machine, and implements the hardware branch stack (PUSH_BRANCH / JUMP_IF / POP).
- Talks to instruction memory over a variable-latency req/ack handshake and to the datapath (ALU, register file, user stack) over a start/done handshake.
- Generalised over word width, branch-stack depth and reset vector.

Parameters:
- WIDTH, 12, width of PC, instruction and jump target
- BSTACK_DEPTH, 8, number of branch-stack entries (>=2)
- RESET_PC, 0, PC value after reset

Ports:
- CLK  in  1  core clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- stall  in  1  holds FETCH before issuing a request
- imem_req  out  1  instruction fetch request
- imem_addr  out  WIDTH  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  WIDTH  fetched instruction
- instr  out  WIDTH  instruction register
- instr_valid  out  1  one-cycle pulse in DECODE
- exec_start  out  1  one-cycle pulse in EXEC
- exec_done  in  1  datapath finished; qualifies pc_op/cond/target
- pc_op  in  3  0 INC, 1 DIRECT, 2 BRANCH_IF, 3 PUSH_BRANCH, 4 POP_BRANCH, 5 HALT, 6-7 treated as INC
- cond  in  1  branch condition for BRANCH_IF
- target  in  WIDTH  jump address (DIRECT) or pushed address (PUSH_BRANCH)
- pc  out  WIDTH  program counter
- state  out  3  FETCH=0 DECODE=1 EXEC=2 WRITE_BACK=3 INCR_PC=4 HALT=5
- halted  out  1  high in HALT
- bs_count  out  $clog2(BSTACK_DEPTH+1)  branch-stack occupancy
- bs_overflow  out  1  sticky: push while full
- bs_underflow  out  1  sticky: branch/pop while empty

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, instr=0, bs_count=0, all flags/pulses/imem_req=0; outputs drop on RESET assertion, not at the next edge. Reset mid-fetch abandons the request; a late imem_ack is ignored.
- FETCH: imem_req=!stall, imem_addr=pc. Once raised, req and addr stay stable until ack, even if stall rises. On req&&ack: instr<=imem_rdata, go DECODE. Ack without req is ignored.
- DECODE: instr_valid=1 for exactly one cycle, go EXEC.
- EXEC: exec_start=1 for exactly one cycle, go WRITE_BACK.
- WRITE_BACK: wait any number of cycles for exec_done. exec_done in any other state is ignored.
- On exec_done, compute next_pc and the stack action, then go INCR_PC. next_pc is applied to pc on the INCR_PC cycle, then go FETCH. Exception: HALT goes straight to HALT.
  - INC: next_pc=pc+1.
  - DIRECT: next_pc=target.
  - BRANCH_IF, cond=1, stack non-empty: next_pc=top entry; no pop.
  - BRANCH_IF, cond=0: next_pc=pc+1; stack per optional feature.
  - BRANCH_IF, empty stack: bs_underflow=1, next_pc=pc+1.
  - PUSH_BRANCH: push target, next_pc=pc+1. If full: no write, bs_overflow=1.
  - POP_BRANCH: discard top, next_pc=pc+1. If empty: bs_underflow=1.
  - HALT: pc unchanged, halted=1; only RESET exits.
- PC arithmetic is modulo 2^WIDTH (all-ones+1 wraps to 0).
- Stack is LIFO; entries are not cleared on pop; bs_count saturates at 0 and BSTACK_DEPTH.
- Sticky flags clear only on RESET.
- Minimum instruction time (ack and done on first cycle): 5 cycles.

Optional Feature:
- Macro: BSTACK_AUTOPOP_EN.
- Defined: BRANCH_IF with cond=0 and a non-empty stack also pops the top entry (loop exit frees its label). Empty stack behaves as above: underflow flagged.
- Undefined: stack unchanged on a not-taken BRANCH_IF; software uses POP_BRANCH explicitly.

Test Plan:
- Reset, ack same cycle as req, INC each instruction -> pc goes 0,1,2; exactly 5 cycles per instruction; instr_valid and exec_start each one cycle wide.
- Ack delayed 3 cycles, stall toggled during the wait -> imem_req/imem_addr stable until ack; instr=imem_rdata; one fetch per instruction.
- PUSH_BRANCH target=0x020, then BRANCH_IF cond=1 at pc=0x025 -> pc=0x020, bs_count=1. Then cond=0 at 0x025 -> pc=0x026; bs_count=0 with BSTACK_AUTOPOP_EN, 1 without.
- Push 9 entries with BSTACK_DEPTH=8 -> bs_count=8, bs_overflow=1, top = 8th pushed value. POP on empty stack -> bs_underflow=1, pc+1.
- pc=0xFFF with INC (WIDTH=12) -> pc=0x000. DIRECT target=0x7A0 -> pc=0x7A0.
- HALT -> halted=1, no further imem_req. RESET asserted mid-WRITE_BACK -> async return to pc=RESET_PC, state=0, all flags 0.
